wildcard_lookup_arbiter: RTL

Shares the single lookup port of the wildcard match stage among `NUM_REQ` requesters: the four Ethernet input paths and the DMA path. It grants requesters round-robin and registers the selected key and packet size onto the lookup bus. A tag FIFO records which requester owns each in-flight lookup, so in-order hit/miss results are steered back to their originators. The block sits between the per-port header parsers and the wildcard match block.

---
 rtl/wildcard_lookup_arbiter_if.sv | 44 ++++
 rtl/wildcard_lookup_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wildcard_lookup_arbiter_if.sv
// Bundles the requester-side and match-stage-side signals of the wildcard lookup arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface wildcard_lookup_arbiter_if #(
    parameter int NUM_REQ        = 5,
    parameter int KEY_WIDTH      = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int PKT_SIZE_WIDTH = 12,
    parameter int TAG_DEPTH_BITS = 3
);
    logic [NUM_REQ-1:0]                req_vld;
    logic [NUM_REQ*KEY_WIDTH-1:0]      req_key;
    logic [NUM_REQ*PKT_SIZE_WIDTH-1:0] req_pkt_size;
    logic [NUM_REQ-1:0]                req_rdy;

    logic [KEY_WIDTH-1:0]              flow_entry;
    logic [PKT_SIZE_WIDTH-1:0]         pkt_size;
    logic                              flow_entry_vld;
    logic                              wildcard_match_rdy;

    logic                              wildcard_data_vld;
    logic                              wildcard_hit;
    logic [DATA_WIDTH-1:0]             wildcard_data;

    logic [NUM_REQ-1:0]                rsp_vld;
    logic                              rsp_hit;
    logic [DATA_WIDTH-1:0]             rsp_data;

    logic [TAG_DEPTH_BITS:0]           outstanding;
    logic                              rsp_orphan_err;

    modport slave (
        input  req_vld, req_key, req_pkt_size, wildcard_match_rdy,
               wildcard_data_vld, wildcard_hit, wildcard_data,
        output req_rdy, flow_entry, pkt_size, flow_entry_vld,
               rsp_vld, rsp_hit, rsp_data, outstanding, rsp_orphan_err
    );

    modport master (
        output req_vld, req_key, req_pkt_size, wildcard_match_rdy,
               wildcard_data_vld, wildcard_hit, wildcard_data,
        input  req_rdy, flow_entry, pkt_size, flow_entry_vld,
               rsp_vld, rsp_hit, rsp_data, outstanding, rsp_orphan_err
    );
endinterface

// File: rtl/wildcard_lookup_arbiter.sv
// Round-robin arbiter sharing the wildcard match lookup port among NUM_REQ requesters,
// with a tag FIFO that steers in-order results back to the requester that issued them.
module wildcard_lookup_arbiter #(
    parameter int NUM_REQ        = 5,
    parameter int KEY_WIDTH      = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int PKT_SIZE_WIDTH = 12,
    parameter int TAG_DEPTH_BITS = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    wildcard_lookup_arbiter_if.slave bus
);
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_DEPTH = 1 << TAG_DEPTH_BITS;

    logic [IDX_W-1:0]          rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]          tagFifo_q [TAG_DEPTH];
    logic [TAG_DEPTH_BITS-1:0] wrPtr_q, rdPtr_q;
    logic [TAG_DEPTH_BITS:0]   outstanding_q, outstanding_d;

    logic [KEY_WIDTH-1:0]      flowEntry_q, flowEntry_d;
    logic [PKT_SIZE_WIDTH-1:0] pktSize_q, pktSize_d;
    logic                      flowEntryVld_q;
    logic [NUM_REQ-1:0]        rspVld_q, rspVld_d;
    logic                      rspHit_q, rspHit_d;
    logic [DATA_WIDTH-1:0]     rspData_q, rspData_d;
    logic                      orphanErr_q, orphanErr_d;

    logic                      grantAllowed;
    logic                      grantVld;
    logic [IDX_W-1:0]          grantIdx;
    logic [IDX_W:0]            scanIdx;
    logic [NUM_REQ-1:0]        reqRdy;
    logic                      push, pop, orphan;
    logic [IDX_W-1:0]          headTag;

    // Reset gates the grant so req_rdy reads 0 while the block is held in reset.
    assign grantAllowed = reset && bus.wildcard_match_rdy &&
                          (outstanding_q < (TAG_DEPTH_BITS+1)'(TAG_DEPTH));

    always_comb begin
        grantVld = 1'b0;
        grantIdx = '0;
        scanIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = {1'b0, rrPtr_q} + (IDX_W+1)'(k);
            if (scanIdx >= (IDX_W+1)'(NUM_REQ)) begin
                scanIdx = scanIdx - (IDX_W+1)'(NUM_REQ);
            end
            if (grantAllowed && !grantVld && bus.req_vld[scanIdx[IDX_W-1:0]]) begin
                grantVld = 1'b1;
                grantIdx = scanIdx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        reqRdy      = '0;
        flowEntry_d = flowEntry_q;
        pktSize_d   = pktSize_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantVld && (grantIdx == IDX_W'(i))) begin
                reqRdy[i]   = 1'b1;
                flowEntry_d = bus.req_key[i*KEY_WIDTH +: KEY_WIDTH];
                pktSize_d   = bus.req_pkt_size[i*PKT_SIZE_WIDTH +: PKT_SIZE_WIDTH];
            end
        end
    end

    // A push in the same cycle does not make the FIFO non-empty for an arriving result.
    assign push    = grantVld;
    assign pop     = bus.wildcard_data_vld && (outstanding_q != '0);
    assign orphan  = bus.wildcard_data_vld && (outstanding_q == '0);
    assign headTag = tagFifo_q[rdPtr_q];

    always_comb begin
        rrPtr_d       = rrPtr_q;
        outstanding_d = outstanding_q;
        rspVld_d      = '0;
        rspHit_d      = rspHit_q;
        rspData_d     = rspData_q;
        orphanErr_d   = orphanErr_q | orphan;

        if (grantVld) begin
            rrPtr_d = (grantIdx == IDX_W'(NUM_REQ-1)) ? '0 : grantIdx + IDX_W'(1);
        end

        if (push && !pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (pop && !push) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        if (pop) begin
            rspHit_d  = bus.wildcard_hit;
            rspData_d = bus.wildcard_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (headTag == IDX_W'(i)) begin
                    rspVld_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr_q        <= '0;
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            outstanding_q  <= '0;
            flowEntry_q    <= '0;
            pktSize_q      <= '0;
            flowEntryVld_q <= 1'b0;
            rspVld_q       <= '0;
            rspHit_q       <= 1'b0;
            rspData_q      <= '0;
            orphanErr_q    <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tagFifo_q[i] <= '0;
            end
        end else begin
            rrPtr_q        <= rrPtr_d;
            outstanding_q  <= outstanding_d;
            flowEntry_q    <= flowEntry_d;
            pktSize_q      <= pktSize_d;
            flowEntryVld_q <= grantVld;
            rspVld_q       <= rspVld_d;
            rspHit_q       <= rspHit_d;
            rspData_q      <= rspData_d;
            orphanErr_q    <= orphanErr_d;
            if (push) begin
                tagFifo_q[wrPtr_q] <= grantIdx;
                wrPtr_q            <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    assign bus.req_rdy        = reqRdy;
    assign bus.flow_entry     = flowEntry_q;
    assign bus.pkt_size       = pktSize_q;
    assign bus.flow_entry_vld = flowEntryVld_q;
    assign bus.rsp_vld        = rspVld_q;
    assign bus.rsp_hit        = rspHit_q;
    assign bus.rsp_data       = rspData_q;
    assign bus.outstanding    = outstanding_q;
    assign bus.rsp_orphan_err = orphanErr_q;

endmodule
